// File: rtl/mem_phase_ctrl.sv
// mem_phase_ctrl
// Phase controller for a load / sort / show memory system.
//   LOAD : each debounced button pulse stores the switch value at the next
//          free index until DEPTH words have been written.
//   SORT : the CPU owns the data memory and runs until it signals halt.
//          Stores outside 0..DEPTH-1 are blocked and flagged.
//   SHOW : the memory is scanned one index every SCAN_DIV clocks for display.
//          This phase is left only through Clr.
// Ports:
//   Clk, Clr                     clock, synchronous active-high reset
//   btn_pulse, sw_data           user write request and the value to store
//   cpu_halt, cpu_mem_we,
//   cpu_addr, cpu_wdata          CPU status and store port (used in SORT only)
//   mem_we, mem_addr, mem_wdata  single-port data memory control
//   cpu_run                      CPU PC-advance enable
//   over, sortover               LOAD finished / SORT finished flags
//   led_onehot                   one-hot index indicator, MSB means index 0
//   addr_err                     sticky flag for an out-of-range CPU store
module mem_phase_ctrl #(
    parameter int DEPTH    = 10,
    parameter int AW       = 4,
    parameter int DW       = 16,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          btn_pulse,
    input  logic [DW-1:0] sw_data,
    input  logic          cpu_halt,
    input  logic          cpu_mem_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_run,
    output logic          over,
    output logic          sortover,
    output logic [DEPTH-1:0] led_onehot,
    output logic          addr_err
);

    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    // Indices are compared one bit wider so DEPTH == 2**AW still works.
    localparam logic [AW:0]     DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, SORT, SHOW} state_t;

    state_t          state;
    logic [AW-1:0]   in_cnt;
    logic [AW-1:0]   scan_idx;
    logic [DIVW-1:0] div;

    logic            load_write;
    logic            bad_store;
    logic [AW:0]     led_k;
    logic            led_en;

    assign load_write = (state == LOAD) && btn_pulse && ({1'b0, in_cnt} < DEPTH_X);
    assign bad_store  = (state == SORT) && cpu_mem_we && ({1'b0, cpu_addr} >= DEPTH_X);

    // Memory port steering and the LED index. Clr forces the memory quiet and
    // points the LED at index 0 immediately, without waiting for the edge.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = in_cnt;
        mem_wdata  = sw_data;
        led_k      = {1'b0, in_cnt};
        led_en     = 1'b1;
        led_onehot = '0;
        case (state)
            LOAD: mem_we = load_write;
            SORT: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_mem_we && !bad_store;
                led_en    = 1'b0;
            end
            SHOW: begin
                mem_addr = scan_idx;
                led_k    = {1'b0, scan_idx};
            end
            default: ;
        endcase
        if (Clr) begin
            mem_we = 1'b0;
            led_k  = '0;
            led_en = 1'b1;
        end
        // An index of DEPTH (LOAD complete) matches no bit, leaving all zero.
        for (int i = 0; i < DEPTH; i++) begin
            led_onehot[i] = led_en && (led_k == (AW+1)'(DEPTH - 1 - i));
        end
    end

    // Phase FSM with registered flags. cpu_run rises on entry to SORT and
    // drops on entry to SHOW, so the CPU still runs in the cycle halt is seen.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state    <= LOAD;
            in_cnt   <= '0;
            scan_idx <= '0;
            div      <= '0;
            over     <= 1'b0;
            sortover <= 1'b0;
            cpu_run  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_write) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST_IDX) begin
                            state   <= SORT;
                            over    <= 1'b1;
                            cpu_run <= 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (bad_store) begin
                        addr_err <= 1'b1;
                    end
                    if (cpu_halt) begin
                        state    <= SHOW;
                        sortover <= 1'b1;
                        cpu_run  <= 1'b0;
                    end
                end
                SHOW: begin
                    if (div == DIV_LAST) begin
                        div      <= '0;
                        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_phase_ctrl.sv
// tb_mem_phase_ctrl
// Directed self-checking bench for mem_phase_ctrl with SCAN_DIV=4.
// Inputs change just after the falling edge; combinational outputs are
// checked a little later in the low phase, registered outputs 1 time unit
// after the rising edge.
module tb_mem_phase_ctrl;

    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int DW    = 16;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          btn_pulse;
    logic [DW-1:0] sw_data;
    logic          cpu_halt;
    logic          cpu_mem_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_run;
    logic          over;
    logic          sortover;
    logic [DEPTH-1:0] led_onehot;
    logic          addr_err;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_phase_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SCAN_DIV(4)) dut (
        .Clk(Clk), .Clr(Clr), .btn_pulse(btn_pulse), .sw_data(sw_data),
        .cpu_halt(cpu_halt), .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .over(over),
        .sortover(sortover), .led_onehot(led_onehot), .addr_err(addr_err)
    );

    // Drive inputs just after the falling edge, then let them settle.
    task automatic drive(input logic clr, input logic btn, input logic [DW-1:0] sw,
                         input logic halt, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        @(negedge Clk);
        Clr = clr; btn_pulse = btn; sw_data = sw;
        cpu_halt = halt; cpu_mem_we = we; cpu_addr = addr; cpu_wdata = wd;
        #2;
    endtask

    task automatic edge_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 4'd3, 16'h5555);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (led_onehot !== 10'b1000000000) begin errors++; $display("[TB] FAIL reset_led: got %b want 1000000000", led_onehot); end
        edge_step();
        checks++; if ({over, sortover, cpu_run, addr_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {over, sortover, cpu_run, addr_err}); end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
        checks++; if (mem_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", mem_addr); end
    endtask

    // Ten writes of 9..0; an idle cycle with CPU activity is slipped in after
    // the third write and must do nothing.
    task automatic test_load();
        logic [DEPTH-1:0] exp_led;
        for (int i = 0; i < DEPTH; i++) begin
            exp_led = 10'b1000000000 >> i;
            drive(1'b0, 1'b1, 16'(9 - i), 1'b0, 1'b1, 4'd7, 16'hBEEF);
            checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL load_we[%0d]: got %b want 1", i, mem_we); end
            checks++; if (mem_addr !== 4'(i)) begin errors++; $display("[TB] FAIL load_addr[%0d]: got %0d want %0d", i, mem_addr, i); end
            checks++; if (mem_wdata !== 16'(9 - i)) begin errors++; $display("[TB] FAIL load_data[%0d]: got %h want %h", i, mem_wdata, 16'(9 - i)); end
            checks++; if (led_onehot !== exp_led) begin errors++; $display("[TB] FAIL load_led[%0d]: got %b want %b", i, led_onehot, exp_led); end
            edge_step();
            checks++; if (over !== (i == DEPTH - 1)) begin errors++; $display("[TB] FAIL load_over[%0d]: got %b want %b", i, over, (i == DEPTH - 1)); end
            if (i == 2) begin
                drive(1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd5, 16'hBEEF);
                checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL load_idle_we: got %b want 0", mem_we); end
                checks++; if (mem_addr !== 4'd3) begin errors++; $display("[TB] FAIL load_idle_addr: got %0d want 3", mem_addr); end
                edge_step();
                checks++; if ({cpu_run, over} !== 2'b00) begin errors++; $display("[TB] FAIL load_halt_ignored: got %b want 00", {cpu_run, over}); end
            end
        end
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("[TB] FAIL sort_cpu_run: got %b want 1", cpu_run); end
    endtask

    task automatic test_sort();
        drive(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 4'd5, 16'h1111);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sort_btn_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 4'd5) begin errors++; $display("[TB] FAIL sort_addr: got %0d want 5", mem_addr); end
        checks++; if (led_onehot !== 10'b0) begin errors++; $display("[TB] FAIL sort_led: got %b want 0", led_onehot); end
        edge_step();
        drive(1'b0, 1'b1, 16'h7777, 1'b0, 1'b1, 4'd3, 16'h00AB);
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd3, 16'h00AB}) begin errors++; $display("[TB] FAIL sort_store: got we=%b addr=%0d data=%h want we=1 addr=3 data=00ab", mem_we, mem_addr, mem_wdata); end
        edge_step();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL sort_no_err: got %b want 0", addr_err); end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd12, 16'h00CD);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sort_bad_we: got %b want 0", mem_we); end
        edge_step();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("[TB] FAIL sort_addr_err: got %b want 1", addr_err); end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd9, 16'h00EE);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL sort_edge_store: got %b want 1", mem_we); end
        edge_step();
    endtask

    task automatic test_show();
        logic [AW-1:0]    exp_idx;
        logic [DEPTH-1:0] exp_led;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000);
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("[TB] FAIL halt_last_run: got %b want 1", cpu_run); end
        edge_step();
        checks++; if ({sortover, cpu_run, addr_err} !== 3'b101) begin errors++; $display("[TB] FAIL show_entry: got %b want 101", {sortover, cpu_run, addr_err}); end
        // CPU keeps storing and halting in SHOW; none of it may reach memory.
        for (int c = 0; c < 44; c++) begin
            exp_idx = 4'((c / 4) % DEPTH);
            exp_led = 10'b1000000000 >> exp_idx;
            drive(1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 4'd2, 16'h4444);
            checks++; if ({mem_we, mem_addr} !== {1'b0, exp_idx}) begin errors++; $display("[TB] FAIL show_scan[%0d]: got we=%b addr=%0d want we=0 addr=%0d", c, mem_we, mem_addr, exp_idx); end
            checks++; if (led_onehot !== exp_led) begin errors++; $display("[TB] FAIL show_led[%0d]: got %b want %b", c, led_onehot, exp_led); end
            edge_step();
        end
    endtask

    task automatic test_clr_show();
        drive(1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b1, 4'd1, 16'h6666);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL clr_show_we: got %b want 0", mem_we); end
        checks++; if (led_onehot !== 10'b1000000000) begin errors++; $display("[TB] FAIL clr_show_led: got %b want 1000000000", led_onehot); end
        edge_step();
        checks++; if ({over, sortover, cpu_run, addr_err} !== 4'b0000) begin errors++; $display("[TB] FAIL clr_show_flags: got %b want 0000", {over, sortover, cpu_run, addr_err}); end
        drive(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 4'd0, 16'h0000);
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 16'h0042}) begin errors++; $display("[TB] FAIL clr_show_reload: got we=%b addr=%0d data=%h want we=1 addr=0 data=0042", mem_we, mem_addr, mem_wdata); end
        edge_step();
    endtask

    task automatic test_clr_sort();
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 16'(i), 1'b0, 1'b0, 4'd0, 16'h0000);
            edge_step();
        end
        checks++; if ({over, cpu_run} !== 2'b11) begin errors++; $display("[TB] FAIL clr_sort_entry: got %b want 11", {over, cpu_run}); end
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd3, 16'h00AB);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL clr_sort_we: got %b want 0", mem_we); end
        edge_step();
        checks++; if ({over, cpu_run, sortover} !== 3'b000) begin errors++; $display("[TB] FAIL clr_sort_flags: got %b want 000", {over, cpu_run, sortover}); end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd6, 16'h0000);
        checks++; if ({mem_we, mem_addr} !== {1'b0, 4'd0}) begin errors++; $display("[TB] FAIL clr_sort_load: got we=%b addr=%0d want we=0 addr=0", mem_we, mem_addr); end
    endtask

    initial begin
        Clr = 1'b1; btn_pulse = 1'b0; sw_data = '0;
        cpu_halt = 1'b0; cpu_mem_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_load();
        test_sort();
        test_show();
        test_clr_show();
        test_clr_sort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_phase_ctrl.md
MEM_PHASE_CTRL -- requirements
Module: mem_phase_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 10: number of data words loaded, sorted and shown.
REQ-002 SHALL have parameter AW, default 4: data memory address width.
REQ-003 SHALL have parameter DW, default 16: data word width.
REQ-004 SHALL have parameter SCAN_DIV, default 50_000_000: Clk cycles per display step in SHOW.
REQ-005 SHALL have port Clk  in  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Clr  in  1: reset, synchronous, active-high.
REQ-007 SHALL have port btn_pulse  in  1: debounced one-cycle write request.
REQ-008 SHALL have port sw_data  in  DW: switch value to store.
REQ-009 SHALL have port cpu_halt  in  1: CPU reached its final instruction.
REQ-010 SHALL have port cpu_mem_we  in  1: CPU store enable.
REQ-011 SHALL have port cpu_addr  in  AW: CPU memory address.
REQ-012 SHALL have port cpu_wdata  in  DW: CPU store data.
REQ-013 SHALL have port mem_we  out  1: write enable to the data memory.
REQ-014 SHALL have port mem_addr  out  AW: the data memory's single address; it is used for both read and write.
REQ-015 SHALL have port mem_wdata  out  DW: data memory write data.
REQ-016 SHALL have ports cpu_run  out  1, over  out  1 and sortover  out  1: the CPU PC-advance enable and two phase flags.
REQ-017 SHALL have ports led_onehot  out  DEPTH and addr_err  out  1: the index indicator and a sticky bad-address flag.

Function
REQ-018 SHALL implement the FSM LOAD -> SORT -> SHOW; SHOW is terminal until Clr.
REQ-019 LOAD, on a btn_pulse with in_cnt < DEPTH: mem_we=1, mem_addr=in_cnt and mem_wdata=sw_data in that cycle, and in_cnt increments at the clock edge.
REQ-020 LOAD, with no btn_pulse: mem_we=0 and mem_addr=in_cnt.
REQ-021 LOAD: when the write at index DEPTH-1 occurs, the FSM SHALL enter SORT on the next edge; over=1 from that edge onward.
REQ-022 SORT: cpu_run=1 and mem_addr=cpu_addr, combinationally, same cycle.
REQ-023 SORT: mem_we=cpu_mem_we and mem_wdata=cpu_wdata, combinationally, same cycle; btn_pulse is ignored.
REQ-024 SORT: a cpu_mem_we with cpu_addr >= DEPTH SHALL force mem_we=0 and set addr_err, which holds until Clr.
REQ-025 SORT: cpu_halt=1 SHALL move to SHOW on the next edge.
REQ-026 On entering SHOW: sortover=1 and cpu_run=0; halt is sampled, so the CPU gets one final cycle with cpu_run=1.
REQ-027 SHOW: mem_we=0 and mem_addr=scan_idx; div counts 0..SCAN_DIV-1; when div reaches SCAN_DIV-1, scan_idx advances, wrapping from DEPTH-1 to 0.
REQ-028 led_onehot SHALL have bit (DEPTH-1-k) set: k=in_cnt in LOAD, k=scan_idx in SHOW, all-zero in SORT; in LOAD with in_cnt=DEPTH it is all-zero.
REQ-029 cpu_mem_we, cpu_addr and cpu_wdata SHALL have no effect outside SORT; cpu_halt SHALL have no effect outside SORT.
REQ-030 Width rule: in_cnt and scan_idx are AW bits wide, and DEPTH <= 2^AW.
REQ-031 Width rule: div is wide enough for SCAN_DIV-1.

Reset
REQ-032 Clr=1 at an edge SHALL set state=LOAD, in_cnt=0, scan_idx=0, div=0, over=0, sortover=0, cpu_run=0 and addr_err=0.
REQ-033 While Clr=1: mem_we=0 and led_onehot=1<<(DEPTH-1), regardless of other inputs.
REQ-034 Clr SHALL override any simultaneous btn_pulse, cpu_halt or cpu store.
REQ-035 Clr mid-SORT or mid-SHOW SHALL return to LOAD with no write issued in the reset cycle.

Verification
REQ-036 10 btn_pulses with sw_data=0x0009..0x0000 -> writes to addr 0..9 in order; over=1 the edge after the 10th write; led 10'b1000000000 -> 10'b0000000001 across the writes.
REQ-037 btn_pulse during SORT -> mem_we follows only cpu_mem_we; SORT store addr=3, data=0x00AB -> mem_we=1, mem_addr=3, mem_wdata=0x00AB in the same cycle.
REQ-038 SORT store addr=12 -> mem_we=0, addr_err=1, which holds into SHOW.
REQ-039 cpu_halt pulse in SORT -> sortover=1 and cpu_run=0 the next cycle; with SCAN_DIV=4, mem_addr steps 0,1,...,9,0 every 4 cycles, and led tracks it.
REQ-040 Clr asserted in SHOW together with btn_pulse -> next cycle state LOAD, over=0, sortover=0, in_cnt=0, no memory write.
